alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Iterative multiply sequencer that borrows the shared 32-bit ALU and computes the low 32 bits of a 32x32 product by shift-and-add, using ALU ADD (Func = 4'b0100) once per iteration. It sits beside the EX stage. While it owns the ALU, it drives `alu_own` to steer the ALU operand mux away from the pipeline. The EX stage stalls on `busy`. Low-word signed and unsigned products are identical, so there is a single op.

## Interface
- `EARLY_EXIT`, default 1: when 1, iterations stop once no higher multiplier bits remain set; when 0, exactly 32 iterations always run.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; operands sampled on the same edge; accepted only in IDLE or DONE.
- `flush` in 1: synchronous abort from pipeline flush.
- `op_a` in 32: multiplicand.
- `op_b` in 32: multiplier.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse; `result` valid.
- `result` out 32: product low word; held until the next completion.
- `alu_own` out 1: sequencer drives the ALU this cycle (high in RUN only).
- `alu_in1` out 32: to ALU In1; equals `acc` in RUN, 0 otherwise.
- `alu_in2` out 32: to ALU In2; equals `mcand` in RUN, 0 otherwise.
- `alu_func` out 4: to ALU Func; 4'b0100 in RUN, 4'b0000 otherwise.
- `alu_out` in 32: ALU result, combinational, same cycle.

## Operation
Internal registers:
- `acc` 32, `mcand` 32, `mplier` 32, `cnt` 5, `state` {IDLE, RUN, DONE}.

IDLE, or DONE with `start`=1 and `flush`=0:
- `mcand`<=`op_a`, `mplier`<=`op_b`, `acc`<=0, `cnt`<=0, then go to RUN.

RUN, each edge:
- If `mplier[0]`, `acc`<=`alu_out`; otherwise `acc` holds.
- `mcand`<=`mcand`<<1.
- `mplier`<=`mplier`>>1.
- `cnt`<=`cnt`+1.

RUN exit, after the current iteration:
- Exit when `cnt`==31.
- With `EARLY_EXIT`=1, also exit when (`mplier`>>1)==0.
- On exit: `result`<=final `acc` value (`alu_out` if `mplier[0]`, else `acc`); go to DONE.

DONE: `done`=1 for exactly one cycle. Next state is IDLE, or RUN if `start` is accepted.

`start` in RUN is ignored (no queueing).

`flush` in RUN or DONE: IDLE next edge.
- `done` is not asserted (in DONE it drops next cycle).
- `result` is unchanged.
- `flush` together with `start` in IDLE or DONE: `flush` wins and the start is dropped.

Arithmetic: all adds are modulo 2^32 and ALU carry is discarded. `mcand` shift discards bit 31.

Iteration count N:
- `EARLY_EXIT`=0: N=32.
- `EARLY_EXIT`=1: N = max(1, index of highest set bit of `op_b` + 1).
- `op_b`=0 gives N=1 and result 0.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `busy`=0, `done`=0, `alu_own`=0, `result`=0, `alu_in1`/`alu_in2`/`alu_func`=0; all internal registers 0.
- Reset during RUN aborts with no `done`, and `alu_own` falls immediately.
- Cycle 0 has `start` high. RUN occupies cycles 1..N with `busy`=`alu_own`=1. `done` is high in cycle N+1.
- Latency: N+1 cycles; worst case 33.
- Back-to-back: `start` in the DONE cycle gives RUN in the next cycle. Throughput is N+1 cycles per op.
- `alu_in1`/`alu_in2`/`alu_func`/`alu_own` decode from registered state only, with no combinational path from `start`.
- There is a combinational loop-free path `acc`/`mcand` -> ALU -> `alu_out` -> `acc` D-input; it must close in one cycle.
- `busy` and `alu_own` are identical. `alu_own` falls in the DONE cycle, so the pipeline regains the ALU there.

## Test plan
- `op_a`=7, `op_b`=6, `EARLY_EXIT`=1 -> `busy` and `alu_own` high in cycles 1-3 with `alu_func`=4'b0100; `done` in cycle 4; `result`=42.
- `op_a`=`op_b`=0xFFFFFFFF -> 32 RUN cycles; `done` in cycle 33; `result`=0x00000001. With `EARLY_EXIT`=0 and `op_b`=3, `done` is still in cycle 33 with result 3*`op_a`.
- `op_a`=0x12345678, `op_b`=0 -> one RUN cycle; `done` in cycle 2; `result`=0. Then `op_a`=0x10000, `op_b`=0x10000 -> `result`=0x00000000 (wrap).
- Previous `result`=42; start 0x12345678 x 0x80000000; `flush` in cycle 5 -> IDLE in cycle 6, `alu_own`=0, no `done`, `result` stays 42. `start` asserted during RUN cycles 2-4 is ignored.
- Run in progress; `rst_n` low mid-cycle 10 -> `busy`/`alu_own`/`done`/`result`/`alu_*` go to 0 without a clock edge. After release, a new 5x5 gives 25.
- 3x4 completes; `start` (9x9) held high in that op's `done` cycle -> new RUN starts the next cycle; second `done` gives 81. `done` pulses are exactly one cycle each.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier that borrows the shared ALU (ADD) once per
// iteration and produces the low 32 bits of a 32x32 product.
//
// state   | meaning
// IDLE    | waiting for start; ALU belongs to the pipeline
// RUN     | one shift-and-add iteration per cycle; sequencer owns the ALU
// DONE    | one-cycle completion pulse; result register freshly updated
module alu_mul_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out
);

    localparam logic [3:0] FUNC_ADD = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_step;
    logic        last_iter;
    logic        in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            result_q <= 32'd0;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        // ALU result is only meaningful here because alu_in*/alu_func are driven in RUN
        acc_step  = mplier_q[0] ? alu_out : acc_q;
        last_iter = (cnt_q == 5'd31) ||
                    (EARLY_EXIT && (mplier_q[31:1] == 31'd0));

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (!flush && start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = {mcand_q[30:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                    cnt_d    = cnt_q + 5'd1;
                    if (last_iter) begin
                        result_d = acc_step;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_run   = (state_q == ST_RUN);
    assign busy     = in_run;
    assign alu_own  = in_run;
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign alu_in1  = in_run ? acc_q   : 32'd0;
    assign alu_in2  = in_run ? mcand_q : 32'd0;
    assign alu_func = in_run ? FUNC_ADD : 4'b0000;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: a behavioural ALU closes the loop and a queue of
// expected products is compared against each completion.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        start_f = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;

    logic        busy, done, alu_own;
    logic [31:0] result, alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_func;

    logic        busy_f, done_f, alu_own_f;
    logic [31:0] result_f, alu_in1_f, alu_in2_f, alu_out_f;
    logic [3:0]  alu_func_f;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_f_q[$];

    always #5 clk = ~clk;

    // Shared ALU model: ADD when asked, otherwise a pipeline-looking garbage value
    assign alu_out   = (alu_func   == 4'b0100) ? alu_in1 + alu_in2     : 32'hDEAD_BEEF;
    assign alu_out_f = (alu_func_f == 4'b0100) ? alu_in1_f + alu_in2_f : 32'hDEAD_BEEF;

    alu_mul_sequencer #(.EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .alu_own(alu_own), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_func(alu_func), .alu_out(alu_out)
    );

    alu_mul_sequencer #(.EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start_f), .flush(flush),
        .op_a(op_a), .op_b(op_b), .busy(busy_f), .done(done_f), .result(result_f),
        .alu_own(alu_own_f), .alu_in1(alu_in1_f), .alu_in2(alu_in2_f),
        .alu_func(alu_func_f), .alu_out(alu_out_f)
    );

    function automatic int n_iter(input logic [31:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hXXXX_XXXX;
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns in cycle 1 with start dropped.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [31:0] p;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        p = a * b;
        if (push) exp_q.push_back(p);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit seen);
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= budget) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, alu_own, done, result, alu_in1, alu_in2, alu_func} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b own=%b done=%b result=%h in1=%h in2=%h func=%h, expected all zero",
                     busy, alu_own, done, result, alu_in1, alu_in2, alu_func);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] e;
        issue(32'd7, 32'd6, 1'b1);
        n_cmp++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd7) begin
            n_err++;
            $display("FAIL basic_operands: got in1=%h in2=%h, expected 0 / 7", alu_in1, alu_in2);
        end
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({busy, alu_own, done, alu_func} !== {1'b1, 1'b1, 1'b0, 4'b0100}) begin
                n_err++;
                $display("FAIL basic_run_c%0d: got busy=%b own=%b done=%b func=%b, expected 1 1 0 0100",
                         c, busy, alu_own, done, alu_func);
            end
            tick();
        end
        e = pop_exp();
        n_cmp++;
        if ({busy, alu_own, done} !== 3'b001 || result !== e) begin
            n_err++;
            $display("FAIL basic_done_c4: got busy=%b own=%b done=%b result=%0d, expected 0 0 1 result=%0d",
                     busy, alu_own, done, result, e);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || alu_func !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_after_done: got done=%b func=%b, expected 0 0000", done, alu_func);
        end
    endtask

    task automatic test_flush();
        issue(32'h1234_5678, 32'h8000_0000, 1'b0);
        tick();
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ignored_start_c%0d: got busy=%b done=%b, expected 1 0", c, busy, done);
            end
            tick();
        end
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({busy, alu_own, done} !== 3'b000 || result !== 32'd42) begin
            n_err++;
            $display("FAIL flush_idle_c6: got busy=%b own=%b done=%b result=%0d, expected 0 0 0 result=42",
                     busy, alu_own, done, result);
        end
        begin
            int hits;
            hits = 0;
            repeat (40) begin
                if (done || busy) hits++;
                tick();
            end
            n_cmp++;
            if (hits != 0 || result !== 32'd42) begin
                n_err++;
                $display("FAIL flush_no_done: got %0d busy/done cycles result=%0d, expected 0 and 42", hits, result);
            end
        end
        // start together with flush in IDLE is dropped
        op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_beats_start: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_products();
        logic [31:0] av[8];
        logic [31:0] bv[8];
        logic [31:0] e;
        int          cyc;
        bit          seen;
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF;
        av[1] = 32'h1234_5678; bv[1] = 32'd0;
        av[2] = 32'h0001_0000; bv[2] = 32'h0001_0000;
        av[3] = 32'hCAFE_F00D; bv[3] = 32'd1;
        for (int i = 4; i < 8; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom >> $urandom_range(0, 31);
        end
        for (int i = 0; i < 8; i++) begin
            issue(av[i], bv[i], 1'b1);
            wait_done(40, cyc, seen);
            e = pop_exp();
            n_cmp++;
            if (!seen || cyc != n_iter(bv[i]) + 1) begin
                n_err++;
                $display("FAIL prod%0d_latency: got done seen=%b at cycle %0d, expected cycle %0d",
                         i, seen, cyc, n_iter(bv[i]) + 1);
            end
            n_cmp++;
            if (result !== e) begin
                n_err++;
                $display("FAIL prod%0d_result: %h*%h got %h, expected %h", i, av[i], bv[i], result, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int          cyc;
        bit          seen;
        issue(32'd3, 32'd4, 1'b1);
        wait_done(40, cyc, seen);
        e = pop_exp();
        n_cmp++;
        if (!seen || cyc != 4 || result !== e) begin
            n_err++;
            $display("FAIL b2b_first: got seen=%b cycle=%0d result=%0d, expected cycle 4 result=%0d",
                     seen, cyc, result, e);
        end
        issue(32'd9, 32'd9, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: got busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_done(40, cyc, seen);
        e = pop_exp();
        n_cmp++;
        if (!seen || cyc != 5 || result !== e) begin
            n_err++;
            $display("FAIL b2b_second: got seen=%b cycle=%0d result=%0d, expected cycle 5 result=%0d",
                     seen, cyc, result, e);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_pulse_width: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] e;
        int          cyc;
        bit          seen;
        issue(32'h0BAD_F00D, 32'hF000_0000, 1'b0);
        repeat (9) tick();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, alu_own, done, result, alu_in1, alu_in2, alu_func} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run: got busy=%b own=%b done=%b result=%h in1=%h in2=%h func=%h, expected all zero",
                     busy, alu_own, done, result, alu_in1, alu_in2, alu_func);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        issue(32'd5, 32'd5, 1'b1);
        wait_done(40, cyc, seen);
        e = pop_exp();
        n_cmp++;
        if (!seen || cyc != 4 || result !== e) begin
            n_err++;
            $display("FAIL reset_then_5x5: got seen=%b cycle=%0d result=%0d, expected cycle 4 result=%0d",
                     seen, cyc, result, e);
        end
        tick();
    endtask

    task automatic test_full_iterations();
        logic [31:0] e;
        logic [31:0] p;
        int          cyc;
        op_a    = 32'h0123_4567;
        op_b    = 32'd3;
        p       = op_a * 32'd3;
        exp_f_q.push_back(p);
        start_f = 1'b1;
        tick();
        start_f = 1'b0;
        cyc = 1;
        while (cyc <= 40 && !done_f) begin
            tick();
            cyc++;
        end
        e = exp_f_q.pop_front();
        n_cmp++;
        if (!done_f || cyc != 33 || result_f !== e) begin
            n_err++;
            $display("FAIL full_iter: got done=%b cycle=%0d result=%h, expected cycle 33 result=%h",
                     done_f, cyc, result_f, e);
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_products();
        test_back_to_back();
        test_reset_mid_run();
        test_full_iterations();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
